// File: rtl/div_unit_pkg.sv
// Shared encodings for the divide engine: FSM state codes, ready levels and the
// stage_ex operator codes that select DIV versus DIVU.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_ON   = 2'b10,
        DIV_END  = 2'b11
    } div_state_e;

    localparam logic DIV_READY     = 1'b1;
    localparam logic DIV_NOT_READY = 1'b0;

    localparam logic [7:0] OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU = 8'b0001_1011;

    // stage_ex uses this to derive signed_i from the decoded operator
    function automatic logic op_is_signed(input logic [7:0] op);
        return op == OP_DIV;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between stage_ex (master) and div_unit (slave).
// div_zero_o is present only when DIV_ZERO_FLAG_EN is defined.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic               start_i;
    logic               signed_i;
    logic               annul_i;
    logic [WIDTH-1:0]   dividend_i;
    logic [WIDTH-1:0]   divisor_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
`ifdef DIV_ZERO_FLAG_EN
    logic               div_zero_o;

    modport master (
        output start_i, signed_i, annul_i, dividend_i, divisor_i,
        input  result_o, ready_o, div_zero_o
    );
    modport slave (
        input  start_i, signed_i, annul_i, dividend_i, divisor_i,
        output result_o, ready_o, div_zero_o
    );
`else
    modport master (
        output start_i, signed_i, annul_i, dividend_i, divisor_i,
        input  result_o, ready_o
    );
    modport slave (
        input  start_i, signed_i, annul_i, dividend_i, divisor_i,
        output result_o, ready_o
    );
`endif
endinterface

// File: rtl/div_unit_sign_fix.sv
// Combinational sign handling: magnitude of the operands on entry, conditional
// negation of quotient/remainder on exit.
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             signed_i,
    output logic             sign_a_o,
    output logic             sign_b_o,
    output logic [WIDTH-1:0] a_abs_o,
    output logic [WIDTH-1:0] b_abs_o,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] rem_i,
    input  logic             neg_quo_i,
    input  logic             neg_rem_i,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o
);
    assign sign_a_o = signed_i & a_i[WIDTH-1];
    assign sign_b_o = signed_i & b_i[WIDTH-1];

    // Most-negative input maps to itself; read as unsigned that is its magnitude
    assign a_abs_o = sign_a_o ? ({WIDTH{1'b0}} - a_i) : a_i;
    assign b_abs_o = sign_b_o ? ({WIDTH{1'b0}} - b_i) : b_i;

    assign quo_o = neg_quo_i ? ({WIDTH{1'b0}} - quo_i) : quo_i;
    assign rem_o = neg_rem_i ? ({WIDTH{1'b0}} - rem_i) : rem_i;
endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring DIV/DIVU engine, one quotient bit per cycle, WIDTH+1 cycles
// to ready (2 for divide-by-zero). Optional div_zero_o flag under DIV_ZERO_FLAG_EN.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic     clock,
    input  logic     reset,
    div_unit_if.slave bus
);
    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH:0]     trial;
    logic               no_borrow;
    logic [WIDTH-1:0]   diff;
    logic               accept;

    div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .a_i       (bus.dividend_i),
        .b_i       (bus.divisor_i),
        .signed_i  (bus.signed_i),
        .sign_a_o  (sign_a),
        .sign_b_o  (sign_b),
        .a_abs_o   (a_abs),
        .b_abs_o   (b_abs),
        .quo_i     (dvd_q),
        .rem_i     (rem_q),
        .neg_quo_i (neg_quo_q),
        .neg_rem_i (neg_rem_q),
        .quo_o     (quo_fix),
        .rem_o     (rem_fix)
    );

    // Dividend register shifts its msb into the remainder and collects quotient bits at the lsb
    assign trial     = {rem_q, dvd_q[WIDTH-1]};
    assign no_borrow = trial >= {1'b0, dvs_q};
    assign diff      = trial[WIDTH-1:0] - dvs_q;
    assign accept    = bus.start_i & ~bus.annul_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            DIV_IDLE: begin
                ready_d  = DIV_NOT_READY;
                result_d = '0;
                if (accept) begin
                    cnt_d = '0;
                    rem_d = '0;
                    if (bus.divisor_i == '0) begin
                        state_d   = DIV_ZERO;
                        dvd_d     = '0;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                    end else begin
                        state_d   = DIV_ON;
                        dvd_d     = a_abs;
                        dvs_d     = b_abs;
                        neg_quo_d = sign_a ^ sign_b;
                        neg_rem_d = sign_a;
                    end
                end
            end
            DIV_ON: begin
                if (bus.annul_i) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = no_borrow ? diff : trial[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], no_borrow};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        state_d = DIV_END;
                    end
                end
            end
            DIV_ZERO: begin
                state_d = bus.annul_i ? DIV_IDLE : DIV_END;
            end
            DIV_END: begin
                // First END cycle publishes the result even if start_i already fell
                if (bus.annul_i) begin
                    state_d  = DIV_IDLE;
                    ready_d  = DIV_NOT_READY;
                    result_d = '0;
                end else if (!ready_q) begin
                    ready_d  = DIV_READY;
                    result_d = {rem_fix, quo_fix};
                end else if (!bus.start_i) begin
                    state_d  = DIV_IDLE;
                    ready_d  = DIV_NOT_READY;
                    result_d = '0;
                end
            end
            default: begin
                state_d  = DIV_IDLE;
                ready_d  = DIV_NOT_READY;
                result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= DIV_NOT_READY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

`ifdef DIV_ZERO_FLAG_EN
    logic dz_q, dz_d;

    assign dz_d = (state_d == DIV_ZERO) | ((state_d == DIV_END) & dz_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dz_q <= 1'b0;
        end else begin
            dz_q <= dz_d;
        end
    end

    assign bus.div_zero_o = dz_q;
`endif
endmodule

// File: tb/tb_div_unit.sv
// Directed vector bench for div_unit: table of DIV/DIVU cases plus hand-written
// annul, reset and early start-drop sequences.
module tb_div_unit;
    import div_unit_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vt[13];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One complete handshake: raise start, wait for ready, check hold and release
    task automatic run_op(input vec_t v, input int idx);
        int lat;
        lat = -1;
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.signed_i   = v.sg;
        bus.dividend_i = v.a;
        bus.divisor_i  = v.b;
        @(posedge clk);
        #1;
        bus.dividend_i = 32'hDEAD_BEEF;
        bus.divisor_i  = 32'h0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) begin
                lat = n;
                break;
            end
        end
        check($sformatf("latency[%0d]", idx), 64'(lat), 64'(v.lat));
        if (lat > 0) begin
            check($sformatf("result[%0d]", idx), bus.result_o, {v.r, v.q});
`ifdef DIV_ZERO_FLAG_EN
            check($sformatf("div_zero[%0d]", idx), 64'(bus.div_zero_o), 64'(v.b == 32'h0));
`endif
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("held_ready[%0d]", idx), 64'(bus.ready_o), 64'd1);
            check($sformatf("held_result[%0d]", idx), bus.result_o, {v.r, v.q});
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("drop_ready[%0d]", idx), 64'(bus.ready_o), 64'd0);
        check($sformatf("drop_result[%0d]", idx), bus.result_o, 64'd0);
    endtask

    initial begin
        int   seen;
        int   lat;
        vec_t v;

        total = 0;
        bad   = 0;
        vt[0]  = '{32'd7,         32'd2,         1'b0, 32'h0000_0003, 32'h0000_0001, 33};
        vt[1]  = '{32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
        vt[2]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0000_0000, 33};
        vt[3]  = '{32'd5,         32'd0,         1'b0, 32'h0000_0000, 32'h0000_0000, 2};
        vt[4]  = '{32'hFFFF_FFFF, 32'd1,         1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        vt[5]  = '{32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'h0000_0001, 33};
        vt[6]  = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'h0000_0003, 32'hFFFF_FFFF, 33};
        vt[7]  = '{32'hFFFF_FFF9, 32'd2,         1'b0, 32'h7FFF_FFFC, 32'h0000_0001, 33};
        vt[8]  = '{32'd100,       32'd3,         1'b0, 32'h0000_0021, 32'h0000_0001, 33};
        vt[9]  = '{32'd3,         32'd7,         1'b0, 32'h0000_0000, 32'h0000_0003, 33};
        vt[10] = '{32'hFFFF_FFFB, 32'd0,         1'b1, 32'h0000_0000, 32'h0000_0000, 2};
        vt[11] = '{32'h1234_5678, 32'h0000_1000, 1'b0, 32'h0001_2345, 32'h0000_0678, 33};
        vt[12] = '{32'h8000_0000, 32'd1,         1'b1, 32'h8000_0000, 32'h0000_0000, 33};

        rst_n          = 1'b0;
        bus.start_i    = 1'b0;
        bus.signed_i   = 1'b0;
        bus.annul_i    = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        #12;
        check("reset_ready", 64'(bus.ready_o), 64'd0);
        check("reset_result", bus.result_o, 64'd0);
        check("reset_state", 64'(dut.state_q), 64'(DIV_IDLE));
`ifdef DIV_ZERO_FLAG_EN
        check("reset_div_zero", 64'(bus.div_zero_o), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(vt[i], i);
        end

        // annul during ON abandons the op; ready must never appear
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.signed_i   = 1'b0;
        bus.dividend_i = 32'd100;
        bus.divisor_i  = 32'd3;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        check("annul_state", 64'(dut.state_q), 64'(DIV_IDLE));
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) seen++;
        end
        check("annul_no_ready", 64'(seen), 64'd0);
        v = '{32'd9, 32'd4, 1'b0, 32'h0000_0002, 32'h0000_0001, 33};
        run_op(v, 100);

        // start_i dropped mid-operation: op still completes and reports once
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.signed_i   = 1'b0;
        bus.dividend_i = 32'd100;
        bus.divisor_i  = 32'd3;
        @(posedge clk);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (n == 5) bus.start_i = 1'b0;
            if (bus.ready_o) begin
                lat = n;
                break;
            end
        end
        check("early_drop_latency", 64'(lat), 64'd33);
        check("early_drop_result", bus.result_o, {32'h1, 32'h21});
        @(posedge clk);
        #1;
        check("early_drop_release", 64'(bus.ready_o), 64'd0);

        // annul while parked in END
        v = '{32'd7, 32'd2, 1'b0, 32'h3, 32'h1, 33};
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.dividend_i = v.a;
        bus.divisor_i  = v.b;
        @(posedge clk);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) begin
                lat = n;
                break;
            end
        end
        check("end_annul_latency", 64'(lat), 64'd33);
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        check("end_annul_ready", 64'(bus.ready_o), 64'd0);
        check("end_annul_state", 64'(dut.state_q), 64'(DIV_IDLE));
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        repeat (2) @(posedge clk);

        // asynchronous reset during ON
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.dividend_i = 32'd100;
        bus.divisor_i  = 32'd3;
        @(posedge clk);
        repeat (15) @(posedge clk);
        #2;
        check("pre_reset_state", 64'(dut.state_q), 64'(DIV_ON));
        rst_n = 1'b0;
        #1;
        check("midop_reset_ready", 64'(bus.ready_o), 64'd0);
        check("midop_reset_result", bus.result_o, 64'd0);
        check("midop_reset_state", 64'(dut.state_q), 64'(DIV_IDLE));
        bus.start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // asynchronous reset while a result is being held
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.signed_i   = 1'b1;
        bus.dividend_i = 32'hFFFF_FFF9;
        bus.divisor_i  = 32'd2;
        @(posedge clk);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) begin
                lat = n;
                break;
            end
        end
        check("end_reset_pre_result", bus.result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        #2;
        rst_n = 1'b0;
        #1;
        check("end_reset_ready", 64'(bus.ready_o), 64'd0);
        check("end_reset_result", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
